// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared pipeline types and constants for the fetch sequencer
//
// Contents:
//   fetch_seq_state_t : 2-bit fetch FSM state (HOLD, FETCH, STALL, KILL)
//   WAIT_CNT_W        : width of the instruction-memory wait counter
//   HOLD_CNT_W        : width of the post-reset hold counter (covers 1..15)
//   wait_sat_inc      : saturating increment for the wait counter
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_KILL  = 2'd3
    } fetch_seq_state_t;

    localparam int WAIT_CNT_W = 8;
    localparam int HOLD_CNT_W = 4;

    function automatic logic [WAIT_CNT_W-1:0] wait_sat_inc(input logic [WAIT_CNT_W-1:0] v);
        return (v == {WAIT_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - fetch-stage sequencer: reset hold, stall, redirect kill, memory timeout
//
// Parameters:
//   RESET_HOLD_CYCLES : cycles fetch stays idle after reset release (1..15)
//   TIMEOUT_CYCLES    : consecutive memory wait cycles that raise timeoutErr (2..255)
// Ports:
//   clock      in  : rising-edge clock
//   rst        in  : asynchronous active-high reset
//   redirect   in  : PC redirect this cycle
//   stallF     in  : hazard-unit fetch freeze
//   imemReady  in  : instruction memory returns data this cycle
//   imemReq    out : fetch request to instruction memory
//   pcEnable   out : PC register load enable
//   pipeEnable out : fetch/decode pipe register enable
//   flushD     out : fetch/decode pipe register clear
//   timeoutErr out : sticky memory-timeout flag (registered)
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int RESET_HOLD_CYCLES = 2,
    parameter int TIMEOUT_CYCLES    = 16
) (
    input  logic clock,
    input  logic rst,
    input  logic redirect,
    input  logic stallF,
    input  logic imemReady,
    output logic imemReq,
    output logic pcEnable,
    output logic pipeEnable,
    output logic flushD,
    output logic timeoutErr
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD   = HOLD_CNT_W'(RESET_HOLD_CYCLES - 1);
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(TIMEOUT_CYCLES);

    fetch_seq_state_t        state;
    fetch_seq_state_t        state_next;
    logic [HOLD_CNT_W-1:0]   hold_cnt;
    logic [WAIT_CNT_W-1:0]   wait_cnt;
    logic [WAIT_CNT_W-1:0]   wait_next;
    logic                    wait_active;

    // Outputs and next state; redirect beats stallF beats imemReady.
    always_comb begin
        imemReq    = 1'b0;
        pcEnable   = 1'b0;
        pipeEnable = 1'b0;
        flushD     = 1'b0;
        state_next = state;
        case (state)
            ST_HOLD: begin
                flushD = 1'b1;
                if (hold_cnt == '0) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imemReq = 1'b1;
                if (redirect) begin
                    pcEnable   = 1'b1;
                    flushD     = 1'b1;
                    // An unreturned fetch must be drained before the next one counts.
                    state_next = imemReady ? ST_FETCH : ST_KILL;
                end else if (stallF) begin
                    state_next = ST_STALL;
                end else if (imemReady) begin
                    pcEnable   = 1'b1;
                    pipeEnable = 1'b1;
                end
            end
            ST_STALL: begin
                if (redirect) begin
                    pcEnable   = 1'b1;
                    flushD     = 1'b1;
                    state_next = ST_FETCH;
                end else if (!stallF) begin
                    state_next = ST_FETCH;
                end
            end
            ST_KILL: begin
                imemReq = 1'b1;
                flushD  = 1'b1;
                if (redirect) begin
                    pcEnable = 1'b1;
                end else if (imemReady) begin
                    // Returned word belongs to the abandoned path; drop it.
                    state_next = ST_FETCH;
                end
            end
            default: begin
                flushD     = 1'b1;
                state_next = ST_HOLD;
            end
        endcase
    end

    // Wait cycles only accumulate while a request stays open across the edge;
    // a return or a move to HOLD/STALL restarts the count.
    always_comb begin
        wait_active = ((state == ST_FETCH) || (state == ST_KILL)) && !imemReady &&
                      ((state_next == ST_FETCH) || (state_next == ST_KILL));
        wait_next   = wait_active ? wait_sat_inc(wait_cnt) : '0;
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state      <= ST_HOLD;
            hold_cnt   <= HOLD_LOAD;
            wait_cnt   <= '0;
            timeoutErr <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            if ((state == ST_HOLD) && (hold_cnt != '0)) begin
                hold_cnt <= hold_cnt - 1'b1;
            end
            if (wait_next == TIMEOUT_VAL) begin
                timeoutErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

    localparam int RHC     = 2;
    localparam int TIMEOUT = 16;

    logic clock = 1'b0;
    logic rst   = 1'b1;
    logic redirect  = 1'b0;
    logic stallF    = 1'b0;
    logic imemReady = 1'b0;
    logic imemReq, pcEnable, pipeEnable, flushD, timeoutErr;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(
        .RESET_HOLD_CYCLES (RHC),
        .TIMEOUT_CYCLES    (TIMEOUT)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .redirect   (redirect),
        .stallF     (stallF),
        .imemReady  (imemReady),
        .imemReq    (imemReq),
        .pcEnable   (pcEnable),
        .pipeEnable (pipeEnable),
        .flushD     (flushD),
        .timeoutErr (timeoutErr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks "cycles of hold left", "frozen by hazard",
    // "stale fetch outstanding" and the length of the current memory wait.
    int   m_hold    = RHC;
    bit   m_stalled = 0;
    bit   m_stale   = 0;
    int   m_waits   = 0;
    bit   m_err     = 0;
    logic e_req, e_pc, e_pipe, e_flush;
    bit   requesting;

    always @(negedge clock) begin
        if (rst) begin
            m_hold = RHC; m_stalled = 0; m_stale = 0; m_waits = 0; m_err = 0;
        end
        if (m_hold > 0) begin
            e_req = 0; e_pc = 0; e_pipe = 0; e_flush = 1;
        end else if (m_stalled) begin
            e_req = 0; e_pipe = 0; e_pc = redirect; e_flush = redirect;
        end else if (m_stale) begin
            e_req = 1; e_pipe = 0; e_flush = 1; e_pc = redirect;
        end else begin
            e_req   = 1;
            e_pc    = redirect || (!stallF && imemReady);
            e_pipe  = !redirect && !stallF && imemReady;
            e_flush = redirect;
        end
        chk("model_imemReq",    imemReq,    e_req);
        chk("model_pcEnable",   pcEnable,   e_pc);
        chk("model_pipeEnable", pipeEnable, e_pipe);
        chk("model_flushD",     flushD,     e_flush);
        chk("model_timeoutErr", timeoutErr, m_err);
        if (!rst) begin
            requesting = (m_hold == 0) && !m_stalled;
            if (m_hold > 0) begin
                m_hold--;
            end else if (m_stalled) begin
                if (redirect || !stallF) m_stalled = 0;
            end else if (m_stale) begin
                if (!redirect && imemReady) m_stale = 0;
            end else if (redirect) begin
                m_stale = !imemReady;
            end else if (stallF) begin
                m_stalled = 1;
            end
            if (requesting && !imemReady && !m_stalled)
                m_waits = (m_waits >= 255) ? 255 : m_waits + 1;
            else
                m_waits = 0;
            if (m_waits == TIMEOUT) m_err = 1;
        end
    end

    task automatic cyc(input logic r, input logic s, input logic rd);
        @(posedge clock); #1;
        redirect = r; stallF = s; imemReady = rd;
        @(negedge clock);
    endtask

    task automatic chk_out(input string name, input logic q, input logic pc, input logic pp, input logic fl);
        chk({name, "_imemReq"},    imemReq,    q);
        chk({name, "_pcEnable"},   pcEnable,   pc);
        chk({name, "_pipeEnable"}, pipeEnable, pp);
        chk({name, "_flushD"},     flushD,     fl);
    endtask

    int starve;

    initial begin
        repeat (3) @(posedge clock);
        #1; rst = 0; imemReady = 1;
        @(negedge clock);
        chk_out("rel_hold1", 0, 0, 0, 1);
        cyc(0, 0, 1); chk_out("rel_hold2", 0, 0, 0, 1);
        cyc(0, 0, 1); chk_out("rel_fetch3", 1, 1, 1, 0);

        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 1); chk_out("stream", 1, 1, 1, 0);
        end

        cyc(1, 0, 0); chk_out("redir_miss", 1, 1, 0, 1);
        cyc(0, 0, 0); chk_out("kill_wait1", 1, 0, 0, 1);
        cyc(0, 0, 0); chk_out("kill_wait2", 1, 0, 0, 1);
        cyc(0, 0, 1); chk_out("kill_drop", 1, 0, 0, 1);
        cyc(0, 0, 1); chk_out("after_kill", 1, 1, 1, 0);

        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 1); chk_out("stall", i == 0, 0, 0, 0);
        end
        cyc(0, 0, 1); chk_out("stall_drop", 0, 0, 0, 0);
        cyc(0, 0, 1); chk_out("resume", 1, 1, 1, 0);
        cyc(0, 1, 1);
        cyc(1, 1, 1); chk_out("stall_redir", 0, 1, 0, 1);
        cyc(0, 0, 1); chk_out("post_redir", 1, 1, 1, 0);

        for (int k = 1; k <= 20; k++) begin
            cyc(0, 0, 0);
            chk("timeout_rise", timeoutErr, k >= TIMEOUT + 1);
        end
        cyc(0, 0, 1); chk("timeout_sticky1", timeoutErr, 1'b1);
        cyc(0, 0, 1); chk("timeout_sticky2", timeoutErr, 1'b1);

        cyc(1, 0, 0);
        cyc(0, 0, 0);
        #2; rst = 1; #1;
        chk_out("async_rst", 0, 0, 0, 1);
        chk("async_rst_err", timeoutErr, 1'b0);
        @(posedge clock); #1;
        @(negedge clock);
        @(posedge clock); #1; rst = 0; imemReady = 1;
        @(negedge clock);
        chk_out("rerel_hold1", 0, 0, 0, 1);
        cyc(0, 0, 1); chk_out("rerel_hold2", 0, 0, 0, 1);
        cyc(0, 0, 1); chk_out("rerel_fetch", 1, 1, 1, 0);

        starve = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 60 == 0) starve = ($urandom % 3 == 0);
            @(posedge clock); #1;
            if (!rst && ($urandom % 400 == 0)) begin
                rst = 1;
            end else begin
                rst = 0;
            end
            redirect  = ($urandom % 9 == 0);
            stallF    = ($urandom % 6 == 0);
            imemReady = starve ? ($urandom % 25 == 0) : ($urandom % 3 != 0);
            if (starve) begin
                redirect = ($urandom % 40 == 0);
                stallF   = ($urandom % 40 == 0);
            end
        end
        @(posedge clock); #1; rst = 0;
        @(negedge clock);
        @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_HOLD_CYCLES, default 2: cycles the fetch stage is held idle after reset release; legal range 1..15.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16: consecutive instruction-memory wait cycles that flag an error; legal range 2..255.
REQ-003 SHALL have port clock  input  1  single clock for all state; rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port redirect  input  1  PC redirect this cycle (Branch or pcSrcW from control).
REQ-006 SHALL have port stallF  input  1  hazard-unit request to freeze fetch.
REQ-007 SHALL have port imemReady  input  1  instruction memory returns valid data this cycle.
REQ-008 SHALL have port imemReq  output  1  instruction fetch request to memory.
REQ-009 SHALL have port pcEnable  output  1  PC register load enable.
REQ-010 SHALL have port pipeEnable  output  1  fetch/decode pipe register enable.
REQ-011 SHALL have port flushD  output  1  clear of the fetch/decode pipe register.
REQ-012 SHALL have port timeoutErr  output  1  sticky memory-timeout flag.

Function
REQ-013 SHALL implement FSM states HOLD, FETCH, STALL, KILL; all outputs are combinational from state and current inputs, except timeoutErr, which is registered.
REQ-014 Priority within any state SHALL be: redirect > stallF > imemReady.
REQ-015 HOLD: imemReq=0, pcEnable=0, pipeEnable=0, flushD=1; inputs ignored; hold counter decrements each cycle; HOLD->FETCH on the edge where counter is 0, giving exactly RESET_HOLD_CYCLES HOLD cycles.
REQ-016 FETCH: imemReq=1; with redirect: pcEnable=1, pipeEnable=0, flushD=1; next state FETCH if imemReady=1, else KILL.
REQ-017 FETCH, stallF=1 and no redirect: pcEnable=0, pipeEnable=0, flushD=0; next state STALL.
REQ-018 FETCH, imemReady=1, no redirect or stall: pcEnable=1, pipeEnable=1, flushD=0; stay FETCH, giving 1 instruction per cycle at zero wait.
REQ-019 FETCH, imemReady=0, no redirect or stall: all enables 0, flushD=0; stay FETCH.
REQ-020 STALL: imemReq=0, pcEnable=0, pipeEnable=0, flushD=0; with redirect: pcEnable=1, flushD=1, go FETCH; with stallF=0: go FETCH; otherwise stay.
REQ-021 KILL (stale fetch outstanding): imemReq=1, pipeEnable=0, flushD=1; with redirect: pcEnable=1, stay KILL; else pcEnable=0 and go FETCH on imemReady=1, discarding the returned word.
REQ-022 The wait counter (8 bit) SHALL increment on each cycle in FETCH or KILL with imemReq=1 and imemReady=0, clear on imemReady=1 or on leaving those states, and saturate at 255.
REQ-023 timeoutErr SHALL set on the edge where the wait counter reaches TIMEOUT_CYCLES, and SHALL stay set until rst.
REQ-024 stallF and redirect SHALL be ignored in HOLD; a simultaneous redirect and stallF SHALL act as redirect only.

Reset
REQ-025 rst=1 SHALL asynchronously force state HOLD, load hold counter RESET_HOLD_CYCLES-1, and clear the wait counter and timeoutErr.
REQ-026 During reset, outputs SHALL be imemReq=0, pcEnable=0, pipeEnable=0, flushD=1, timeoutErr=0.
REQ-027 Reset asserted mid-operation, in any state, SHALL abandon the outstanding fetch; the first imemReq after release follows the HOLD sequence.

Structure
REQ-028 The state enum (fetch_seq_state_t, 2 bit) and constant WAIT_CNT_W=8 SHALL live in the shared pipeline package.
REQ-029 The block SHALL be a single module with no sub-modules; counters are inline.

Verification
REQ-030 Release reset with default parameters -> flushD=1 and imemReq=0 for exactly 2 cycles; imemReq=1 in cycle 3.
REQ-031 FETCH with imemReady=1 held for 5 cycles -> pcEnable=pipeEnable=1 on all 5; flushD=0 throughout.
REQ-032 FETCH with imemReady=0 and a redirect pulse -> KILL; imemReady=1 after 3 cycles -> pipeEnable stays 0, flushD=1 until return, then FETCH.
REQ-033 stallF=1 for 4 cycles -> pcEnable=pipeEnable=0 for 4 cycles; fetch resumes the cycle after stallF drops; redirect with stallF=1 -> pcEnable=1, flushD=1.
REQ-034 imemReady=0 for 20 cycles with TIMEOUT_CYCLES=16 -> timeoutErr rises after the 16th wait cycle and stays 1 until rst.
REQ-035 Assert rst in KILL mid-wait -> outputs take reset values immediately (asynchronously); HOLD replays for 2 cycles after release.
